// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
//   Byte-addressed data memory for the MEM stage. It handles sized loads
//   (byte/half/word/dword) with zero or sign extension, and sized stores that
//   merge into byte lanes. It detects misaligned and out-of-range accesses and
//   supports a fixed number of wait states. The memory is an array of SIZE
//   64-bit doublewords, little-endian.
//
//   The array has no reset and is not preloaded. Nothing is initialised from a
//   file, so the contents are undefined until they are written.
//
// Handshake (both channels): a transfer happens on a rising edge where valid
//   and ready are both high. req_ready depends only on the FSM state. Once
//   resp_valid is raised, it stays high with stable resp_rdata and resp_fault
//   until the edge that samples resp_ready high.
//
// Ports
//   clk         in   1   clock, all state on rising edge
//   rst         in   1   asynchronous active-high reset
//   req_valid   in   1   request present
//   req_ready   out  1   high only in IDLE
//   req_write   in   1   1 = store, 0 = load
//   req_size    in   2   00 byte, 01 half, 10 word, 11 dword
//   req_signed  in   1   loads: 1 = sign-extend, 0 = zero-extend
//   req_addr    in   64  byte address
//   req_wdata   in   64  store data, right-justified
//   resp_valid  out  1   response present
//   resp_ready  in   1   consumer takes response
//   resp_rdata  out  64  extended load data, 0 for stores and faults
//   resp_fault  out  1   misaligned or out-of-range access
//   dbg_state   out  2   current FSM state (0 IDLE, 1 WAIT, 2 ACCESS, 3 RESP)
// -----------------------------------------------------------------------------
module data_memory_ctrl #(
  parameter int SIZE        = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic [1:0]  dbg_state
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_wait_cnt;

  // Request fields latched on accept.
  logic          r_write;
  logic          r_signed;
  logic [1:0]    r_size;
  logic [63:0]   r_addr;
  logic [63:0]   r_wdata;

  // Results of the ACCESS cycle: the raw dword and the fault flag.
  logic [63:0]   r_word;
  logic          r_fault_q;

  // Response registers.
  logic          r_resp_valid;
  logic [63:0]   r_rdata;
  logic          r_fault;

  logic [63:0]   r_mem [SIZE];

  logic          w_misaligned;
  logic          w_out_of_range;
  logic          w_fault;
  logic [AW-1:0] w_idx;
  logic [63:0]   w_old;
  logic [5:0]    w_lane_sh;
  logic [7:0]    w_size_be;
  logic [7:0]    w_be;
  logic [63:0]   w_bit_mask;
  logic [63:0]   w_merged;
  logic          w_do_write;
  logic [63:0]   w_shifted;
  logic [63:0]   w_ext;
  logic [63:0]   w_load_data;

  // ---------------------------------------------------------------------------
  // Address decode, fault detection and store merge.
  // These use only the latched request, so no req_* input can reach resp_*.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_misaligned = 1'b0;
    w_size_be    = 8'h01;
    case (r_size)
      2'b00: begin w_misaligned = 1'b0;              w_size_be = 8'h01; end
      2'b01: begin w_misaligned = r_addr[0];         w_size_be = 8'h03; end
      2'b10: begin w_misaligned = |r_addr[1:0];      w_size_be = 8'h0F; end
      default: begin w_misaligned = |r_addr[2:0];    w_size_be = 8'hFF; end
    endcase
  end

  assign w_out_of_range = (r_addr[63:3] >= 61'(SIZE));
  assign w_fault        = w_misaligned | w_out_of_range;
  assign w_idx          = r_addr[3 +: AW];
  assign w_old          = r_mem[w_idx];
  assign w_lane_sh      = {r_addr[2:0], 3'b000};

  // The access is aligned, so the shifted byte enables never spill past lane 7.
  assign w_be = w_size_be << r_addr[2:0];

  always_comb begin
    w_bit_mask = '0;
    for (int k = 0; k < 8; k++) begin
      w_bit_mask[8*k +: 8] = {8{w_be[k]}};
    end
  end

  assign w_merged   = (w_old & ~w_bit_mask) | ((r_wdata << w_lane_sh) & w_bit_mask);
  assign w_do_write = (r_state == S_ACCESS) && r_write && !w_fault;

  // The array is kept out of the async-reset block. Reset still blocks a
  // pending write, because it forces the FSM out of ACCESS.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the dword captured in ACCESS.
  // ---------------------------------------------------------------------------
  assign w_shifted = r_word >> w_lane_sh;

  always_comb begin
    w_ext = w_shifted;
    case (r_size)
      2'b00:   w_ext = {{56{r_signed & w_shifted[7]}},  w_shifted[7:0]};
      2'b01:   w_ext = {{48{r_signed & w_shifted[15]}}, w_shifted[15:0]};
      2'b10:   w_ext = {{32{r_signed & w_shifted[31]}}, w_shifted[31:0]};
      default: w_ext = w_shifted;
    endcase
  end

  assign w_load_data = (r_write || r_fault_q) ? 64'd0 : w_ext;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 4'(WAIT_STATES - 1)) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: w_next = S_RESP;
      S_RESP: begin
        if (r_resp_valid && resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_write      <= 1'b0;
      r_signed     <= 1'b0;
      r_size       <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_word       <= '0;
      r_fault_q    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_fault      <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_signed   <= req_signed;
            r_size     <= req_size;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= (w_next == S_ACCESS) ? 4'd0 : r_wait_cnt + 4'd1;
        end
        S_ACCESS: begin
          r_fault_q <= w_fault;
          r_word    <= w_fault ? 64'd0 : w_old;
        end
        S_RESP: begin
          // The first RESP cycle formats the result. After that, the response
          // is held until it is taken.
          if (!r_resp_valid) begin
            r_resp_valid <= 1'b1;
            r_rdata      <= w_load_data;
            r_fault      <= r_fault_q;
          end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_fault = r_fault;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_memory_ctrl
//   Three instances that differ only in WAIT_STATES (0, 2, 3), indexed as
//   dut 0, 1, 2. All stimulus is driven and all outputs are sampled on the
//   falling clock edge.
// -----------------------------------------------------------------------------
module tb_data_memory_ctrl;

  localparam int SIZE = 1024;
  localparam int W    = 65;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [1:0]  req_size   [3];
  logic        req_signed [3];
  logic [63:0] req_addr   [3];
  logic [63:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [63:0] resp_rdata [3];
  logic        resp_fault [3];
  logic [1:0]  dbg_state  [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   sb_mem [128];

  // ---------------------------------------------------------------------------
  // Clock and DUTs
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  data_memory_ctrl #(.SIZE(SIZE), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]), .dbg_state(dbg_state[0])
  );

  data_memory_ctrl #(.SIZE(SIZE), .WAIT_STATES(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]), .dbg_state(dbg_state[1])
  );

  data_memory_ctrl #(.SIZE(SIZE), .WAIT_STATES(3)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
    .req_size(req_size[2]), .req_signed(req_signed[2]), .req_addr(req_addr[2]),
    .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_fault(resp_fault[2]), .dbg_state(dbg_state[2])
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic issue_req(input int d, input logic wr, input logic [1:0] sz,
                           input logic sg, input logic [63:0] a, input logic [63:0] wd);
    int t;
    t = 0;
    while (req_ready[d] !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (req_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_timeout dut%0d: req_ready=%b, required 1", d, req_ready[d]);
    end
    req_write[d]  = wr;
    req_size[d]   = sz;
    req_signed[d] = sg;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    req_valid[d]  = 1'b1;
    @(negedge clk);
    // Scramble the fields once the request is taken. The DUT must have latched them.
    req_valid[d]  = 1'b0;
    req_write[d]  = 1'($urandom_range(0, 1));
    req_size[d]   = 2'($urandom_range(0, 3));
    req_signed[d] = 1'($urandom_range(0, 1));
    req_addr[d]   = {$urandom(), $urandom()};
    req_wdata[d]  = {$urandom(), $urandom()};
  endtask

  // Returns the number of rising edges from the accept edge to resp_valid.
  task automatic wait_resp(input int d, output int lat);
    lat = 0;
    while (resp_valid[d] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (resp_valid[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL resp_timeout dut%0d: resp_valid=%b, required 1", d, resp_valid[d]);
    end
  endtask

  task automatic finish_resp(input int d);
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
  endtask

  task automatic do_op(input int d, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] wd,
                       output logic [63:0] rd, output logic flt);
    int lat;
    issue_req(d, wr, sz, sg, a, wd);
    wait_resp(d, lat);
    rd  = resp_rdata[d];
    flt = resp_fault[d];
    finish_resp(d);
  endtask

  function automatic logic [63:0] model_load(input int a, input int n, input logic sg);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = sb_mem[a+i];
    if (sg && n < 8 && v[8*n-1]) begin
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (req_ready[d] !== 1'b1) begin
        n_fail++; $display("FAIL reset_req_ready dut%0d: got %b, required 1", d, req_ready[d]);
      end
      n_checks++;
      if (resp_valid[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_resp_valid dut%0d: got %b, required 0", d, resp_valid[d]);
      end
      n_checks++;
      if (resp_rdata[d] !== 64'd0) begin
        n_fail++; $display("FAIL reset_resp_rdata dut%0d: got %h, required 0", d, resp_rdata[d]);
      end
      n_checks++;
      if (resp_fault[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_resp_fault dut%0d: got %b, required 0", d, resp_fault[d]);
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [63:0] rd;
    logic        f;
    int          seen;
    do_op(2, 1'b1, 2'b11, 1'b0, 64'h40, 64'hA5A5_A5A5_A5A5_A5A5, rd, f);
    issue_req(2, 1'b1, 2'b11, 1'b0, 64'h40, 64'h5555_6666_7777_8888);
    n_checks++;
    if (dbg_state[2] !== 2'd1) begin
      n_fail++; $display("FAIL rstwait_in_wait: state=%0d, required 1", dbg_state[2]);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (resp_valid[2] !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_valid_during: got %b, required 0", resp_valid[2]);
    end
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (req_ready[2] !== 1'b1) begin
      n_fail++; $display("FAIL rstwait_req_ready: got %b, required 1", req_ready[2]);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid[2] === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rstwait_no_resp: resp_valid high %0d cycles, required 0", seen);
    end
    do_op(2, 1'b0, 2'b11, 1'b0, 64'h40, 64'd0, rd, f);
    n_checks++;
    if (rd !== 64'hA5A5_A5A5_A5A5_A5A5 || f !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_readback: got %h/%b, required a5a5a5a5a5a5a5a5/0", rd, f);
    end
  endtask

  task automatic test_sized_load;
    logic [1:0]  sz_t  [6] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00};
    logic        sg_t  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [63:0] a_t   [6] = '{64'h13, 64'h16, 64'h14, 64'h14, 64'h10, 64'h10};
    logic [63:0] exp_t [6] = '{64'h55, 64'h1122, 64'h1122_3344, 64'h1122_3344,
                               64'h7788, 64'hFFFF_FFFF_FFFF_FF88};
    logic [63:0] rd;
    logic        f;
    do_op(0, 1'b1, 2'b11, 1'b0, 64'h10, 64'h1122_3344_5566_7788, rd, f);
    n_checks++;
    if (rd !== 64'd0 || f !== 1'b0) begin
      n_fail++; $display("FAIL sized_store_resp: got %h/%b, required 0/0", rd, f);
    end
    for (int i = 0; i < 6; i++) begin
      do_op(0, 1'b0, sz_t[i], sg_t[i], a_t[i], 64'd0, rd, f);
      n_checks++;
      if (rd !== exp_t[i] || f !== 1'b0) begin
        n_fail++;
        $display("FAIL sized_load_%0d @%h: got %h/%b, required %h/0", i, a_t[i], rd, f, exp_t[i]);
      end
    end
  endtask

  task automatic test_byte_merge;
    logic [1:0]  sz_t  [6] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b01, 2'b11};
    logic        sg_t  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] a_t   [6] = '{64'h21, 64'h21, 64'h20, 64'h20, 64'h26, 64'h20};
    logic [63:0] exp_t [6] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'hF0, 64'hF000,
                               64'hBEEF_0000_0000_F000, 64'hFFFF_FFFF_FFFF_BEEF,
                               64'hBEEF_0000_89AB_CDEF};
    logic [63:0] rd;
    logic        f;
    do_op(0, 1'b1, 2'b11, 1'b0, 64'h20, 64'd0, rd, f);
    do_op(0, 1'b1, 2'b00, 1'b0, 64'h21, 64'h1234_5678_9ABC_DEF0, rd, f);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) do_op(0, 1'b1, 2'b01, 1'b0, 64'h26, 64'h7777_7777_7777_BEEF, rd, f);
      if (i == 5) do_op(0, 1'b1, 2'b10, 1'b0, 64'h20, 64'hFFFF_0000_89AB_CDEF, rd, f);
      do_op(0, 1'b0, sz_t[i], sg_t[i], a_t[i], 64'd0, rd, f);
      n_checks++;
      if (rd !== exp_t[i] || f !== 1'b0) begin
        n_fail++;
        $display("FAIL merge_%0d @%h: got %h/%b, required %h/0", i, a_t[i], rd, f, exp_t[i]);
      end
    end
  endtask

  task automatic test_faults;
    logic [63:0] rd;
    logic        f;
    do_op(0, 1'b1, 2'b11, 1'b0, 64'h0, 64'h0123_4567_89AB_CDEF, rd, f);
    do_op(0, 1'b1, 2'b00, 1'b0, 64'(SIZE*8-1), 64'h5A, rd, f);
    begin
      logic        wr_t  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [1:0]  sz_t  [8] = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01};
      logic [63:0] a_t   [8] = '{64'h12, 64'h11, 64'h4, 64'(SIZE*8), 64'h2,
                                 64'(SIZE*8), 64'h8000_0000_0000_0000, 64'h7};
      for (int i = 0; i < 8; i++) begin
        do_op(0, wr_t[i], sz_t[i], 1'b1, a_t[i], 64'hFFFF_FFFF_FFFF_FFFF, rd, f);
        n_checks++;
        if (rd !== 64'd0 || f !== 1'b1) begin
          n_fail++;
          $display("FAIL fault_%0d @%h: got %h/%b, required 0/1", i, a_t[i], rd, f);
        end
      end
    end
    do_op(0, 1'b0, 2'b11, 1'b0, 64'h0, 64'd0, rd, f);
    n_checks++;
    if (rd !== 64'h0123_4567_89AB_CDEF || f !== 1'b0) begin
      n_fail++; $display("FAIL fault_no_write: got %h/%b, required 0123456789abcdef/0", rd, f);
    end
    do_op(0, 1'b0, 2'b00, 1'b0, 64'(SIZE*8-1), 64'd0, rd, f);
    n_checks++;
    if (rd !== 64'h5A || f !== 1'b0) begin
      n_fail++; $display("FAIL top_byte: got %h/%b, required 5a/0", rd, f);
    end
  endtask

  task automatic test_latency;
    int          lat_t [3] = '{2, 4, 5};
    logic [63:0] rd;
    logic        f;
    logic [63:0] exp_v;
    int          lat;
    for (int d = 0; d < 3; d++) begin
      exp_v = 64'hC0FF_EE00_0000_0000 + 64'(d);
      do_op(d, 1'b1, 2'b11, 1'b0, 64'h30, exp_v, rd, f);
      issue_req(d, 1'b0, 2'b11, 1'b0, 64'h30, 64'd0);
      wait_resp(d, lat);
      n_checks++;
      if (lat != lat_t[d]) begin
        n_fail++; $display("FAIL latency dut%0d: got %0d cycles, required %0d", d, lat, lat_t[d]);
      end
      for (int c = 0; c < 5; c++) begin
        n_checks++;
        if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== exp_v || resp_fault[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL hold dut%0d cyc%0d: valid=%b rdata=%h fault=%b, required 1/%h/0",
                   d, c, resp_valid[d], resp_rdata[d], resp_fault[d], exp_v);
        end
        n_checks++;
        if (req_ready[d] !== 1'b0) begin
          n_fail++; $display("FAIL hold_req_ready dut%0d cyc%0d: got %b, required 0", d, c, req_ready[d]);
        end
        @(negedge clk);
      end
      finish_resp(d);
      n_checks++;
      if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL after_hs dut%0d: req_ready=%b resp_valid=%b, required 1/0",
                 d, req_ready[d], resp_valid[d]);
      end
      // Issue the next request straight after the handshake.
      do_op(d, 1'b0, 2'b00, 1'b0, 64'h30 + 64'(d), 64'd0, rd, f);
      n_checks++;
      if (rd !== 64'h00 || f !== 1'b0) begin
        n_fail++; $display("FAIL back_to_back dut%0d: got %h/%b, required 0/0", d, rd, f);
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] rd;
    logic        f;
    logic [63:0] wd;
    logic [W-1:0] e;
    for (int i = 0; i < 16; i++) begin
      wd = {$urandom(), $urandom()};
      do_op(0, 1'b1, 2'b11, 1'b0, 64'(8*i), wd, rd, f);
      for (int b = 0; b < 8; b++) sb_mem[8*i+b] = wd[8*b +: 8];
    end
    for (int op = 0; op < 6000; op++) begin
      logic        wr;
      logic [1:0]  sz;
      logic        sg;
      logic [63:0] a;
      logic [63:0] ev;
      logic        ef;
      int          n;
      int          r;
      int          lat;
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      wd = {$urandom(), $urandom()};
      n  = 1 << int'(sz);
      r  = $urandom_range(0, 15);
      if (r == 0)      a = 64'(SIZE*8 + $urandom_range(0, 64));
      else if (r == 1) a = 64'($urandom_range(0, 127));
      else             a = 64'($urandom_range(0, 127)) & ~64'(n - 1);
      ef = ((a & 64'(n - 1)) != 0) || (a >= 64'(SIZE*8));
      ev = '0;
      if (!ef) begin
        if (wr) begin
          for (int b = 0; b < n; b++) sb_mem[int'(a)+b] = wd[8*b +: 8];
        end else begin
          ev = model_load(int'(a), n, sg);
        end
      end
      exp_q.push_back({ef, ev});
      issue_req(0, wr, sz, sg, a, wd);
      wait_resp(0, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (resp_rdata[0] !== e[63:0] || resp_fault[0] !== e[64]) begin
        n_fail++;
        $display("FAIL random op%0d wr=%b sz=%0d sg=%b @%h: got %h/%b, required %h/%b",
                 op, wr, sz, sg, a, resp_rdata[0], resp_fault[0], e[63:0], e[64]);
      end
      finish_resp(0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    for (int d = 0; d < 3; d++) begin
      req_valid[d]  = 1'b0;
      req_write[d]  = 1'b0;
      req_size[d]   = 2'b00;
      req_signed[d] = 1'b0;
      req_addr[d]   = '0;
      req_wdata[d]  = '0;
      resp_ready[d] = 1'b0;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    test_reset;
    test_sized_load;
    test_byte_merge;
    test_faults;
    test_latency;
    test_reset_mid_wait;
    test_random;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
